// File: rtl/bridge_pkg.sv
// ============================================================================
// Module   : bridge_pkg
// Purpose  : State encoding and protocol byte constants for the UART bus bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_BUS    = 3'd3,
        ST_RDWAIT = 3'd4,
        ST_TXLOAD = 3'd5,
        ST_TXWAIT = 3'd6
    } state_t;

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    function automatic logic [31:0] shift_in_byte(input logic [31:0] acc, input logic [7:0] b);
        return {acc[23:0], b};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bridge_timeout.sv
// ============================================================================
// Module   : bridge_timeout
// Purpose  : Inter-byte gap counter; expire is high in the TIMEOUT_CYC-th idle cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bridge_timeout #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] c_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count_q, count_d;

    assign expire = (count_q == c_LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (!expire) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_bus_bridge.sv
// ============================================================================
// Module   : uart_bus_bridge
// Purpose  : Decodes UART command frames into single bus reads/writes and replies.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bus_bridge #(
    parameter int ADDR_BYTES  = 4,
    parameter int DATA_BYTES  = 4,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  UART_RXD,
    input  logic        RX_EFF,
    output logic        RX_READ,
    output logic [7:0]  UART_TXD,
    input  logic        TX_STATUS,
    output logic        TX_EN,
    output logic        read,
    output logic        write,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy,
    output logic [7:0]  err_cnt
);
    import bridge_pkg::*;

    localparam logic [2:0] c_ADDR_LAST = 3'(ADDR_BYTES - 1);
    localparam logic [2:0] c_DATA_LAST = 3'(DATA_BYTES - 1);
    localparam logic [2:0] c_RD_LAST   = 3'(RD_LAT - 1);
    localparam int         c_RD_SHIFT  = 32 - 8 * DATA_BYTES;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        skip_q, skip_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] addr_sh_q, addr_sh_d;
    logic [31:0] data_sh_q, data_sh_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] tx_sh_q, tx_sh_d;
    logic [2:0]  tx_n_q, tx_n_d;
    logic        tx_low_q, tx_low_d;
    logic [7:0]  err_q, err_d;

    logic w_rx_state, w_rx_take, w_tmo_clear, w_tmo_expire;
    logic w_err_inc, w_tx_en, w_rd_stb, w_wr_stb;

    // A byte is taken only in receive states and never in the cycle right after a take.
    assign w_rx_state  = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign w_rx_take   = reset && w_rx_state && RX_EFF && !skip_q;
    assign w_tmo_clear = w_rx_take || !((state_q == ST_ADDR) || (state_q == ST_DATA));

    bridge_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .sysclk (sysclk),
        .reset  (reset),
        .clear  (w_tmo_clear),
        .expire (w_tmo_expire)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        skip_d    = w_rx_take;
        is_wr_d   = is_wr_q;
        addr_sh_d = addr_sh_q;
        data_sh_d = data_sh_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_sh_d   = tx_sh_q;
        tx_n_d    = tx_n_q;
        tx_low_d  = tx_low_q;
        err_d     = err_q;
        w_err_inc = 1'b0;
        w_tx_en   = 1'b0;
        w_rd_stb  = 1'b0;
        w_wr_stb  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_rx_take) begin
                    cnt_d = 3'd0;
                    if (UART_RXD == CMD_WR || UART_RXD == CMD_RD) begin
                        is_wr_d   = (UART_RXD == CMD_WR);
                        addr_sh_d = '0;
                        data_sh_d = '0;
                        state_d   = ST_ADDR;
                    end else begin
                        tx_sh_d   = {NAK, 24'h0};
                        tx_n_d    = 3'd0;
                        w_err_inc = 1'b1;
                        state_d   = ST_TXLOAD;
                    end
                end
            end
            ST_ADDR: begin
                if (w_rx_take) begin
                    addr_sh_d = shift_in_byte(addr_sh_q, UART_RXD);
                    cnt_d     = cnt_q + 3'd1;
                    if (cnt_q == c_ADDR_LAST) begin
                        cnt_d = 3'd0;
                        if (is_wr_q) begin
                            state_d = ST_DATA;
                        end else begin
                            addr_d  = addr_sh_d;
                            state_d = ST_BUS;
                        end
                    end
                end else if (w_tmo_expire) begin
                    w_err_inc = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_rx_take) begin
                    data_sh_d = shift_in_byte(data_sh_q, UART_RXD);
                    cnt_d     = cnt_q + 3'd1;
                    if (cnt_q == c_DATA_LAST) begin
                        cnt_d   = 3'd0;
                        addr_d  = addr_sh_q;
                        wdata_d = data_sh_d;
                        state_d = ST_BUS;
                    end
                end else if (w_tmo_expire) begin
                    w_err_inc = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_BUS: begin
                cnt_d = 3'd0;
                if (is_wr_q) begin
                    w_wr_stb = 1'b1;
                    tx_sh_d  = {ACK, 24'h0};
                    tx_n_d   = 3'd0;
                    state_d  = ST_TXLOAD;
                end else begin
                    w_rd_stb = 1'b1;
                    state_d  = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == c_RD_LAST) begin
                    // Left-justify so the most significant response byte sits on top.
                    tx_sh_d = rdata << c_RD_SHIFT;
                    tx_n_d  = c_DATA_LAST;
                    cnt_d   = 3'd0;
                    state_d = ST_TXLOAD;
                end
            end
            ST_TXLOAD: begin
                if (TX_STATUS) begin
                    w_tx_en  = 1'b1;
                    tx_low_d = 1'b0;
                    state_d  = ST_TXWAIT;
                end
            end
            ST_TXWAIT: begin
                if (!TX_STATUS) begin
                    tx_low_d = 1'b1;
                end else if (tx_low_q) begin
                    if (cnt_q == tx_n_q) begin
                        cnt_d   = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                        tx_sh_d = {tx_sh_q[23:0], 8'h00};
                        state_d = ST_TXLOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_err_inc && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            skip_q    <= 1'b0;
            is_wr_q   <= 1'b0;
            addr_sh_q <= '0;
            data_sh_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_sh_q   <= '0;
            tx_n_q    <= 3'd0;
            tx_low_q  <= 1'b0;
            err_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            skip_q    <= skip_d;
            is_wr_q   <= is_wr_d;
            addr_sh_q <= addr_sh_d;
            data_sh_q <= data_sh_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_sh_q   <= tx_sh_d;
            tx_n_q    <= tx_n_d;
            tx_low_q  <= tx_low_d;
            err_q     <= err_d;
        end
    end

    assign RX_READ  = w_rx_take;
    assign TX_EN    = w_tx_en;
    assign read     = w_rd_stb;
    assign write    = w_wr_stb;
    assign addr     = addr_q;
    assign wdata    = wdata_q;
    assign UART_TXD = tx_sh_q[31:24];
    assign busy     = (state_q != ST_IDLE);
    assign err_cnt  = err_q;

endmodule

`default_nettype wire
